// File: rtl/mixed_bmem_arbiter_pkg.sv
// Purpose: shared types for the B-memory arbiter (wordline address, FSM state, response record).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// bmem_cfg_pkg supplies the B-memory geometry; mixed_bmem_package builds the arbiter types on it.
// Optional zero-fill after reset is selected by the MIXED_BMEM_INIT_EN macro in the top level.

package bmem_cfg_pkg;
    localparam int BSIZE      = 10;  // wordlines in the B memory
    localparam int BSIZE_LOG2 = 4;   // wordline address width
endpackage

package mixed_bmem_package;
    import bmem_cfg_pkg::*;

    // Winner index width covers the largest supported requester count (4).
    localparam int WIN_W = 2;

    typedef logic [BSIZE_LOG2-1:0] bmemAddr_t;
    typedef logic [WIN_W-1:0]      bmemIdx_t;

    // Highest legal wordline; anything above it is answered with an error.
    localparam bmemAddr_t BMEM_LAST = bmemAddr_t'(BSIZE - 1);

    typedef enum logic {
        INIT,
        RUN
    } bmemState_t;

    typedef struct packed {
        bmemIdx_t winner;
        logic     is_read;
        logic     err;
    } bmemRsp_t;
endpackage

// File: rtl/mixed_bmem_arbiter_rr.sv
// Purpose: round-robin arbiter over NREQ request lines, holding the priority pointer.
// Latency: grant/winner are combinational from req and the pointer; pointer updates on the advance edge.
// Backpressure: none internally; the pointer only moves when advance is high.
// Ports: clk, rst_n (async active-low), req[NREQ], advance -> grant[NREQ] (one-hot or zero), winner index.

module mixed_rr_arb
    import mixed_bmem_package::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output bmemIdx_t        winner
);

    bmemIdx_t ptr;
    bmemIdx_t win_lo;
    bmemIdx_t win_hi;
    logic     any_lo;
    logic     any_hi;

    // Two searches: the lowest requester at or above the pointer wins; if there is
    // none, wrap around to the lowest requester overall.
    always_comb begin
        win_lo = '0;
        win_hi = '0;
        any_lo = 1'b0;
        any_hi = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                any_lo = 1'b1;
                win_lo = bmemIdx_t'(j);
                if (bmemIdx_t'(j) >= ptr) begin
                    any_hi = 1'b1;
                    win_hi = bmemIdx_t'(j);
                end
            end
        end
        winner = any_hi ? win_hi : win_lo;
        grant  = any_lo ? (NREQ'(1) << winner) : '0;
    end

    // Winner drops to lowest priority for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (winner == bmemIdx_t'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/mixed_bmem_arbiter.sv
// Purpose: shares one single-port B memory among NREQ requesters, flagging out-of-range addresses.
// Latency: accept to rsp_valid is exactly one cycle; one access per cycle, no bubbles.
// Backpressure: req_ready is a one-hot round-robin grant (zero during init/reset); responses cannot stall.
// Ports: req_* (packed per requester), rsp_* (rdata/err shared, valid per requester),
//        mem_* to the memory macro (rdata valid the cycle after a read strobe), init_done.
// Option: define MIXED_BMEM_INIT_EN to zero-fill every wordline after reset before accepting traffic.

module mixed_bmem_arbiter
    import bmem_cfg_pkg::*;
    import mixed_bmem_package::*;
#(
    parameter int DATA_W = 32,
    parameter int NREQ   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*BSIZE_LOG2-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0]     req_wdata,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_en,
    output logic                       mem_we,
    output bmemAddr_t                  mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       init_done
);

`ifdef MIXED_BMEM_INIT_EN
    localparam bmemState_t RESET_STATE = INIT;
    bmemAddr_t init_cnt;
`else
    localparam bmemState_t RESET_STATE = RUN;
`endif

    bmemState_t        state_q;
    bmemState_t        state_d;
    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   grant;
    bmemIdx_t          winner;
    logic              accept;
    logic              in_range;
    logic              sel_write;
    bmemAddr_t         sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rsp_vld_q;
    bmemRsp_t          rsp_q;

    // Requests are only visible to the arbiter in RUN, and never while reset is held,
    // so req_ready sits at zero during reset regardless of req_valid.
    assign arb_req = (state_q == RUN && rst_n) ? req_valid : '0;
    assign accept  = |grant;

    mixed_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (accept),
        .grant   (grant),
        .winner  (winner)
    );

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr  = req_addr[i*BSIZE_LOG2 +: BSIZE_LOG2];
                sel_write = req_write[i];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_range = (sel_addr <= BMEM_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
`ifdef MIXED_BMEM_INIT_EN
            INIT: begin
                // Zero-fill sweep; strobes held low while reset is asserted.
                mem_en   = rst_n;
                mem_we   = rst_n;
                mem_addr = init_cnt;
                if (init_cnt == BMEM_LAST) begin
                    state_d = RUN;
                end
            end
`endif
            RUN: begin
                req_ready = grant;
                // Out-of-range accepts never reach the memory.
                if (accept && in_range) begin
                    mem_en    = 1'b1;
                    mem_we    = sel_write;
                    mem_addr  = sel_addr;
                    mem_wdata = sel_wdata;
                end
            end
            default: ;
        endcase
    end

`ifdef MIXED_BMEM_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (state_q == INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end
`endif

    // One-stage response record; a new accept overwrites it every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
        end else begin
            rsp_vld_q <= accept;
            if (accept) begin
                rsp_q.winner  <= winner;
                rsp_q.is_read <= ~sel_write;
                rsp_q.err     <= ~in_range;
            end
        end
    end

    assign rsp_valid = rsp_vld_q ? (NREQ'(1) << rsp_q.winner) : '0;
    assign rsp_rdata = (rsp_vld_q && rsp_q.is_read && !rsp_q.err) ? mem_rdata : '0;
    assign rsp_err   = rsp_vld_q && rsp_q.err;
    assign init_done = (state_q == RUN);

endmodule

// File: tb/tb_mixed_bmem_arbiter.sv
// Purpose: directed bench for mixed_bmem_arbiter with a memory stub and a behavioural reference.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps

module tb_mixed_bmem_arbiter;
    localparam int DATA_W = 32;
    localparam int NREQ   = 2;
    localparam int AW     = 4;
    localparam int BS     = 10;
`ifdef MIXED_BMEM_INIT_EN
    localparam bit INIT_ON = 1'b1;
`else
    localparam bit INIT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*AW-1:0]     req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   mem_en;
    logic                   mem_we;
    logic [AW-1:0]          mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata = '0;
    logic                   init_done;

    mixed_bmem_arbiter #(.DATA_W(DATA_W), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .init_done(init_done)
    );

    function automatic logic [DATA_W-1:0] pat(input logic [AW-1:0] a);
        return 32'hA5A5_0000 | {28'd0, a};
    endfunction

    // Memory macro stub: unwritten wordlines read as a recognisable pattern.
    logic [DATA_W-1:0] mem [16];
    logic [15:0]       mem_written = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]         <= mem_wdata;
                mem_written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= mem_written[mem_addr] ? mem[mem_addr] : pat(mem_addr);
            end
        end
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [16];
    logic [15:0]       ref_wr = '0;
    int  m_ptr = 0;
    bit  m_run = !INIT_ON;
    int  m_icnt = 0;
    bit  m_pend = 1'b0;
    int  m_pwin = 0;
    bit  m_pread = 1'b0;
    bit  m_perr = 1'b0;
    logic [DATA_W-1:0] m_pdata = '0;
    bit  m_acc;
    int  m_win;
    int  m_a;
    int  m_c;
    logic [NREQ-1:0]        vsh;
    logic [NREQ-1:0]        wsh;
    logic [NREQ*AW-1:0]     ash;
    logic [NREQ*DATA_W-1:0] dsh;

    logic [NREQ-1:0]   exp_ready, exp_rspv;
    logic              exp_men, exp_mwe, exp_err, exp_done;
    logic [AW-1:0]     exp_maddr;
    logic [DATA_W-1:0] exp_mwd, exp_rdata;

    // Hand-computed expectations, set by the stimulus for the current cycle.
    bit                lit_rdy_on, lit_rsp_on, lit_mem_on, lit_done_on;
    logic [NREQ-1:0]   lit_rdy, lit_rspv;
    logic [DATA_W-1:0] lit_rdata;
    logic              lit_err, lit_men, lit_done;
    logic [AW-1:0]     lit_maddr;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [DATA_W-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : pat(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Compare process: expected outputs from round-robin rules, checked every negedge.
    always @(negedge clk) begin
        exp_ready = '0; exp_men = 1'b0; exp_mwe = 1'b0; exp_maddr = '0; exp_mwd = '0;
        m_acc = 1'b0; m_win = 0; m_a = 0;
        if (rst_n && m_run) begin
            for (int k = 0; k < NREQ; k++) begin
                m_c = (m_ptr + k) % NREQ;
                vsh = req_valid >> m_c;
                if (!m_acc && vsh[0]) begin
                    m_acc = 1'b1;
                    m_win = m_c;
                end
            end
            if (m_acc) begin
                ash = req_addr >> (m_win * AW);
                dsh = req_wdata >> (m_win * DATA_W);
                wsh = req_write >> m_win;
                m_a = int'(ash[AW-1:0]);
                exp_ready = NREQ'(1) << m_win;
                if (m_a < BS) begin
                    exp_men   = 1'b1;
                    exp_mwe   = wsh[0];
                    exp_maddr = ash[AW-1:0];
                    exp_mwd   = dsh[DATA_W-1:0];
                end
            end
        end else if (rst_n && !m_run) begin
            exp_men   = 1'b1;
            exp_mwe   = 1'b1;
            exp_maddr = AW'(m_icnt);
        end
        exp_rspv  = m_pend ? (NREQ'(1) << m_pwin) : '0;
        exp_rdata = (m_pend && m_pread && !m_perr) ? m_pdata : '0;
        exp_err   = m_pend && m_perr;
        exp_done  = m_run;

        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("mem_en", 64'(mem_en), 64'(exp_men));
        chk("mem_we", 64'(mem_we), 64'(exp_mwe));
        chk("mem_addr", 64'(mem_addr), 64'(exp_maddr));
        chk("mem_wdata", 64'(mem_wdata), 64'(exp_mwd));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rspv));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        chk("init_done", 64'(init_done), 64'(exp_done));
        if (lit_rdy_on) chk("lit_req_ready", 64'(req_ready), 64'(lit_rdy));
        if (lit_rsp_on) begin
            chk("lit_rsp_valid", 64'(rsp_valid), 64'(lit_rspv));
            chk("lit_rsp_rdata", 64'(rsp_rdata), 64'(lit_rdata));
            chk("lit_rsp_err", 64'(rsp_err), 64'(lit_err));
        end
        if (lit_mem_on) begin
            chk("lit_mem_en", 64'(mem_en), 64'(lit_men));
            chk("lit_mem_addr", 64'(mem_addr), 64'(lit_maddr));
        end
        if (lit_done_on) chk("lit_init_done", 64'(init_done), 64'(lit_done));
    end

    // Model state update on the clock edge (uses the decision made at the preceding negedge).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_pend = 1'b0; m_run = !INIT_ON; m_icnt = 0;
        end else if (!m_run) begin
            ref_mem[AW'(m_icnt)] = '0;
            ref_wr[AW'(m_icnt)]  = 1'b1;
            if (m_icnt == BS - 1) m_run = 1'b1;
            else m_icnt++;
        end else begin
            m_pend = m_acc;
            if (m_acc) begin
                m_pwin  = m_win;
                m_pread = !wsh[0];
                m_perr  = (m_a >= BS);
                m_pdata = ref_rd(AW'(m_a));
                if (!m_perr && wsh[0]) begin
                    ref_mem[AW'(m_a)] = dsh[DATA_W-1:0];
                    ref_wr[AW'(m_a)]  = 1'b1;
                end
                m_ptr = (m_win + 1) % NREQ;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        lit_rdy_on = 0; lit_rsp_on = 0; lit_mem_on = 0; lit_done_on = 0;
    endtask

    task automatic drive(input int r, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DATA_W-1:0] d);
        if (r == 0) begin
            req_valid[0] = v; req_write[0] = w; req_addr[3:0] = a; req_wdata[31:0] = d;
        end else begin
            req_valid[1] = v; req_write[1] = w; req_addr[7:4] = a; req_wdata[63:32] = d;
        end
    endtask

    task automatic lit_reset();
        lit_rdy_on = 1; lit_rdy = '0;
        lit_rsp_on = 1; lit_rspv = '0; lit_rdata = '0; lit_err = 1'b0;
        lit_mem_on = 1; lit_men = 1'b0; lit_maddr = '0;
        lit_done_on = 1; lit_done = !INIT_ON;
    endtask

    task automatic set_rdy(input logic [NREQ-1:0] r);
        lit_rdy_on = 1; lit_rdy = r;
    endtask

    task automatic set_rsp(input logic [NREQ-1:0] v, input logic [DATA_W-1:0] d, input logic e);
        lit_rsp_on = 1; lit_rspv = v; lit_rdata = d; lit_err = e;
    endtask

    // Release reset; with zero-fill compiled in, pin the ten-write sweep cycle by cycle.
    task automatic release_rst(input int nwr);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < nwr; i++) begin
            if (i > 0) cyc();
            lit_mem_on = 1; lit_men = 1'b1; lit_maddr = AW'(i);
            lit_done_on = 1; lit_done = 1'b0;
        end
    endtask

    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        lit_rdy_on = 0; lit_rsp_on = 0; lit_mem_on = 0; lit_done_on = 0;
        lit_rdy = '0; lit_rspv = '0; lit_rdata = '0; lit_err = 0;
        lit_men = 0; lit_maddr = '0; lit_done = 0;

        cyc(); lit_reset();
        cyc(); lit_reset();
        if (INIT_ON) begin
            // Reset at counter 5 restarts the sweep from address 0.
            release_rst(5);
            cyc(); rst_n = 1'b0; lit_reset();
            release_rst(BS);
        end else begin
            release_rst(0);
        end

        // Read address 7: zero after the sweep, stub pattern otherwise.
        cyc(); drive(0, 1, 0, 4'd7, '0); set_rdy(2'b01);
        lit_done_on = 1; lit_done = 1'b1;
        cyc(); drive(0, 0, 0, 4'd0, '0); set_rsp(2'b01, INIT_ON ? 32'h0 : 32'hA5A5_0007, 1'b0);

        // Write then read address 3 from requester 0.
        cyc(); drive(0, 1, 1, 4'd3, 32'hDEAD_BEEF); set_rdy(2'b01);
        lit_mem_on = 1; lit_men = 1'b1; lit_maddr = 4'd3;
        cyc(); drive(0, 1, 0, 4'd3, '0); set_rdy(2'b01); set_rsp(2'b01, 32'h0, 1'b0);
        cyc(); drive(0, 0, 0, 4'd0, '0); set_rsp(2'b01, 32'hDEAD_BEEF, 1'b0);

        // Requester 1 reads out-of-range address 12.
        cyc(); drive(1, 1, 0, 4'd12, '0); set_rdy(2'b10);
        lit_mem_on = 1; lit_men = 1'b0; lit_maddr = 4'd0;
        cyc(); drive(1, 0, 0, 4'd0, '0); set_rsp(2'b10, 32'h0, 1'b1);

        // Both requesters hold valid for six cycles: strict alternation.
        cyc(); drive(0, 1, 1, 4'd5, 32'h1234_5678); drive(1, 1, 0, 4'd3, '0); set_rdy(2'b01);
        cyc(); set_rdy(2'b10); set_rsp(2'b01, 32'h0, 1'b0);
        cyc(); set_rdy(2'b01); set_rsp(2'b10, 32'hDEAD_BEEF, 1'b0);
        cyc(); set_rdy(2'b10);
        cyc(); set_rdy(2'b01);
        cyc(); set_rdy(2'b10);
        cyc(); drive(0, 0, 0, 4'd0, '0); drive(1, 0, 0, 4'd0, '0); set_rsp(2'b10, 32'hDEAD_BEEF, 1'b0);

        // Boundary addresses: 10 is an error, 9 is the last legal wordline.
        cyc(); drive(0, 1, 0, 4'd10, '0); drive(1, 1, 1, 4'd9, 32'hCAFE_F00D); set_rdy(2'b01);
        lit_mem_on = 1; lit_men = 1'b0; lit_maddr = 4'd0;
        cyc(); drive(0, 0, 0, 4'd0, '0); set_rdy(2'b10); set_rsp(2'b01, 32'h0, 1'b1);
        lit_mem_on = 1; lit_men = 1'b1; lit_maddr = 4'd9;
        cyc(); drive(1, 0, 0, 4'd0, '0); drive(0, 1, 0, 4'd9, '0); set_rdy(2'b01);
        set_rsp(2'b10, 32'h0, 1'b0);
        cyc(); drive(0, 0, 0, 4'd0, '0); set_rsp(2'b01, 32'hCAFE_F00D, 1'b0);

        // Reset the cycle after an accept: response dropped, pointer back to 0.
        cyc(); drive(0, 1, 0, 4'd3, '0); set_rdy(2'b01);
        cyc(); drive(0, 0, 0, 4'd0, '0); rst_n = 1'b0; lit_reset();
        cyc(); lit_reset();
        release_rst(INIT_ON ? BS : 0);
        cyc(); drive(0, 1, 0, 4'd1, '0); drive(1, 1, 0, 4'd2, '0); set_rdy(2'b01);
        cyc(); drive(0, 0, 0, 4'd0, '0); set_rdy(2'b10);
        cyc(); drive(1, 0, 0, 4'd0, '0);
        cyc();
        cyc();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mixed_bmem_arbiter.md
# mixed_bmem_arbiter

Shares one single-port memory of BSIZE wordlines (BSIZE = 10, address width BSIZE_LOG2 = 4) between NREQ requesters. Round-robin arbitration, one access per cycle, fixed one-cycle response. Flags out-of-range addresses (addr ≥ BSIZE) with an error response and does not touch the memory for them. Optionally zero-fills the whole memory after reset before accepting traffic. Sits between the requesting blocks and the B memory macro.

## Interface
Parameters:
- DATA_W, 32, wordline data width
- NREQ, 2, number of requesters (2..4)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*BSIZE_LOG2  packed wordline addresses, requester i at [i*BSIZE_LOG2 +: BSIZE_LOG2]
- req_wdata  in  NREQ*DATA_W  packed write data
- rsp_valid  out  NREQ  one-cycle response pulse to the accepted requester
- rsp_rdata  out  DATA_W  read data; shared by all requesters, qualified by rsp_valid
- rsp_err  out  1  address out of range; qualified by rsp_valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  BSIZE_LOG2  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we = 0
- init_done  out  1  high once the block accepts requests

## Operation
States:
- INIT: only when MIXED_BMEM_INIT_EN is compiled in.
- RUN

INIT:
- Counter walks 0..BSIZE-1, one write of zeros per cycle: mem_en = mem_we = 1, mem_wdata = 0.
- req_ready = 0.
- After address BSIZE-1 the FSM moves to RUN and init_done rises.

RUN, arbitration:
- Each cycle, the arbiter grants one valid requester in round-robin order.
- The priority pointer starts at requester 0 after reset.
- After each grant the pointer moves to the requester after the winner, so the winner has lowest priority next cycle.
- The pointer does not move when nothing is granted.
- req_ready[winner] is combinational from req_valid and the pointer. The accept happens on the cycle where valid and ready are both high.

RUN, memory access on accept:
- Address < BSIZE: mem_en = 1, mem_we = req_write, mem_addr and mem_wdata taken from the winner, all in the same cycle.
- Address ≥ BSIZE (10..15): mem_en = 0; an error is recorded instead.

Response:
- The winner index, the error flag and the read/write type go into a one-stage response register.
- On the next cycle rsp_valid[winner] = 1.
- rsp_rdata = mem_rdata for a valid read, 0 for writes and for errors.
- rsp_err = 1 only for out-of-range accesses.
- Back-to-back accepts are allowed: throughput is one request per cycle, with no bubbles.

Reset:
- While rst_n is low, all state clears and the response register empties.
- Reset in mid-INIT restarts INIT from address 0.
- Reset in RUN drops any in-flight response; no rsp_valid is issued for it.

## Timing
Reset values of outputs:
- req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- init_done = 0 when MIXED_BMEM_INIT_EN is compiled in, 1 otherwise.

Latency:
- Accept to rsp_valid is exactly 1 cycle for both reads and writes.
- With init compiled in, init_done rises BSIZE (10) cycles after rst_n deasserts; the first accept is possible that cycle.

Arbitration:
- A requester whose req_valid is held high is granted within NREQ cycles.
- Requesters must hold req_valid and the request fields stable until accepted.

## Configuration
MIXED_BMEM_INIT_EN:
- Defined: the INIT state and the wordline counter are compiled in and the memory is zero-filled after every reset.
- Undefined: the FSM starts in RUN, init_done is tied to 1, and requests can be accepted in the first cycle after reset.

## Structure
Shared package mixed_bmem_package. It imports the package that supplies BSIZE and BSIZE_LOG2, and defines:
- bmemAddr_t, logic [BSIZE_LOG2-1:0]
- bmemState_t enum {INIT, RUN}
- bmemRsp_t struct {winner index, is_read, err}

One sub-module, mixed_rr_arb:
- Parameter NREQ.
- Inputs: req vector, advance strobe. Outputs: one-hot grant, winner index.
- Holds the priority pointer.

## Test plan
- Init on: release reset → 10 zero writes to addresses 0..9 on consecutive cycles, then init_done = 1; reading address 7 returns 0.
- Req0 writes 0xDEADBEEF to address 3, then reads address 3 → the write response has rsp_rdata = 0, rsp_err = 0; the read response has rsp_rdata = 0xDEADBEEF exactly one cycle after accept.
- Both requesters hold valid for 6 cycles → grants alternate 0,1,0,1,0,1 with no idle cycle.
- Req1 reads address 12 → mem_en stays 0; next cycle rsp_valid[1] = 1, rsp_err = 1, rsp_rdata = 0.
- Assert rst_n low at INIT counter = 5, then release → the sweep restarts at address 0, with 10 more writes before init_done.
- Reset asserted the cycle after an accept → no rsp_valid, all outputs at their reset values, pointer back to requester 0.
